// File: rtl/uart_pkg.sv
// Shared definitions for the UART RX frame checker: parity-mode codes,
// minimum data length and the per-entry error flag bundle.
package uart_pkg;

  localparam logic [2:0] PAR_NONE  = 3'b000;
  localparam logic [2:0] PAR_EVEN  = 3'b001;
  localparam logic [2:0] PAR_ODD   = 3'b010;
  localparam logic [2:0] PAR_MARK  = 3'b011;
  localparam logic [2:0] PAR_SPACE = 3'b100;

  localparam int DATA_LEN_MIN = 5;

  typedef struct packed {
    logic par_err;
    logic frm_err;
    logic brk;
  } frame_flags_t;

endpackage

// File: rtl/uart_sat_counter.sv
// Saturating event counter; a clear coinciding with an increment restarts at 1.
module uart_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = inc ? CNT_W'(1) : '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/uart_rx_frame_check.sv
// UART RX frame checker: parity/stop checks into a one-entry output stage,
// sticky status and saturating error counters. Break detection: UART_BREAK_DETECT_EN.
module uart_rx_frame_check
  import uart_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        data_len,
  input  logic [2:0]        parity_mode,
  input  logic              frame_valid,
  input  logic [DWIDTH-1:0] p_data,
  input  logic              parity_bit,
  input  logic              stop_bit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_par_err,
  output logic              out_frm_err,
  output logic              out_break,
  input  logic              sts_clr,
  output logic              sts_par,
  output logic              sts_frm,
  output logic              sts_ovr,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  par_err_cnt,
  output logic [CNT_W-1:0]  frm_err_cnt
);

  logic [3:0]        len_eff;
  logic [DWIDTH-1:0] md;
  logic              par_chk;
  logic              par_exp;
  frame_flags_t      flags_in;
  logic              load;
  logic              ovr;

  logic              out_valid_q, out_valid_d;
  logic [DWIDTH-1:0] out_data_q, out_data_d;
  frame_flags_t      out_flags_q, out_flags_d;
  logic              sts_par_q, sts_par_d;
  logic              sts_frm_q, sts_frm_d;
  logic              sts_ovr_q, sts_ovr_d;

  // Evaluate the frame currently on the inputs with the live configuration.
  always_comb begin
    len_eff = data_len;
    if ((data_len < 4'(DATA_LEN_MIN)) || (data_len > 4'(DWIDTH))) begin
      len_eff = 4'(DWIDTH);
    end
    md = '0;
    for (int i = 0; i < DWIDTH; i++) begin
      md[i] = p_data[i] & (i < int'(len_eff));
    end
    par_chk = 1'b1;
    par_exp = 1'b0;
    case (parity_mode)
      PAR_EVEN:  par_exp = ^md;
      PAR_ODD:   par_exp = ~^md;
      PAR_MARK:  par_exp = 1'b1;
      PAR_SPACE: par_exp = 1'b0;
      default:   par_chk = 1'b0;
    endcase
    flags_in.par_err = par_chk && (parity_bit != par_exp);
    flags_in.frm_err = !stop_bit;
    flags_in.brk     = 1'b0;
`ifdef UART_BREAK_DETECT_EN
    if ((md == '0) && !stop_bit && (!par_chk || !parity_bit)) begin
      flags_in.brk     = 1'b1;
      flags_in.par_err = 1'b0;
      flags_in.frm_err = 1'b0;
    end
`endif
  end

  // Output handshake: an entry is consumed on the edge where out_valid && out_ready;
  // while out_valid && !out_ready the entry and its flags are held unchanged.
  assign load = frame_valid && (!out_valid_q || out_ready);
  assign ovr  = frame_valid && out_valid_q && !out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_flags_d = out_flags_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = md;
      out_flags_d = flags_in;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    // Set wins over a same-cycle clear.
    sts_par_d = (sts_par_q && !sts_clr) || (load && flags_in.par_err);
    sts_frm_d = (sts_frm_q && !sts_clr) || (load && flags_in.frm_err);
    sts_ovr_d = (sts_ovr_q && !sts_clr) || ovr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_flags_q <= '0;
      sts_par_q   <= 1'b0;
      sts_frm_q   <= 1'b0;
      sts_ovr_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_flags_q <= out_flags_d;
      sts_par_q   <= sts_par_d;
      sts_frm_q   <= sts_frm_d;
      sts_ovr_q   <= sts_ovr_d;
    end
  end

  uart_sat_counter #(.CNT_W(CNT_W)) u_par_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (load && flags_in.par_err),
    .clr   (cnt_clr),
    .count (par_err_cnt)
  );

  uart_sat_counter #(.CNT_W(CNT_W)) u_frm_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (load && flags_in.frm_err),
    .clr   (cnt_clr),
    .count (frm_err_cnt)
  );

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_par_err = out_flags_q.par_err;
  assign out_frm_err = out_flags_q.frm_err;
  assign out_break   = out_flags_q.brk;
  assign sts_par     = sts_par_q;
  assign sts_frm     = sts_frm_q;
  assign sts_ovr     = sts_ovr_q;

endmodule
